muldiv_issue: RTL and testbench
===============================

Name: muldiv_issue

Overview:
- Issue/collect stage directly upstream of the iterative divider (ALU_div) and its sibling multiplier.
- Accepts one M-extension op from execute, holds operands and valid stable for the unit, and captures the 128-bit {hi,lo} result on the unit's one-cycle ok pulse.
- Selects and sign-extends the architectural 64-bit result and holds it for the writeback handshake.
- Stalls the pipe while busy; supports flush.

Parameters:
- XLEN, 64, operand/result width; the units are fixed 64-bit, so only 64 is legal.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  op offered by execute
- in_ready  out  1  block can accept an op (state IDLE)
- in_op  in  3  muldiv_op_t (MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM, REMU)
- in_w  in  1  word (*W) variant
- in_a, in_b  in  64 each  rs1 / rs2 values
- flush  in  1  kill in-flight op
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_data  out  64  final result
- div_valid  out  1  to divider valid; held high for the whole op
- div_a, div_b  out  64 each  latched operands
- div_uors  out  1  1 = signed
- div_w  out  1  word flag
- div_ok  in  1  divider done pulse
- div_c  in  128  {remainder, quotient}
- mul_valid, mul_a, mul_b, mul_signs(2), mul_w, mul_ok, mul_c(128)  same contract toward the multiplier; mul_c = {hi, lo}

Behaviour:
- Reset (reset=0, async): state=IDLE; in_ready=1; out_valid=0; div_valid=mul_valid=0; out_data=0; all operand registers=0.
- States: IDLE, WAIT_DIV, WAIT_MUL, DONE.
- IDLE:
  - in_valid&in_ready latches op, w, a, b.
  - Next state is WAIT_DIV for DIV/DIVU/REM/REMU, WAIT_MUL otherwise.
- WAIT_DIV:
  - div_valid=1 every cycle; operands and flags are driven from the latch, never from in_*.
  - On div_ok=1: capture div_c the same cycle, go to DONE.
  - div_valid is registered from state, so it is low the cycle after ok. This prevents a divider restart.
- WAIT_MUL: identical, using mul_*.
- Latency:
  - in_ready is 0 from the cycle after accept until DONE drains.
  - out_valid rises the cycle after ok.
  - Total latency = unit latency + 1; the divider takes 65 cycles for nonzero b, 2 for b=0.
- DONE:
  - out_valid=1; out_data is stable until out_ready=1.
  - Handshake: DONE -> IDLE. No new accept in the same cycle (one op in flight, no bypass).
- Result select:
  - DIV/DIVU: c[63:0]. REM/REMU: c[127:64]. MUL: c[63:0]. MULH*: c[127:64].
  - If w=1: out_data = sign-extend of the selected bits [31:0]. This includes DIVUW/REMUW, per ISA.
- Signedness:
  - div_uors=1 for DIV/REM.
  - mul_signs={a_signed,b_signed}: MULH 11, MULHSU 10, MULHU/MUL 00.
- Divide-by-zero: no special case here. The divider returns quotient all-ones and remainder = dividend, which matches ISA after the w sign-extend (DIVW x/0 -> 0xFFFF_FFFF_FFFF_FFFF).
- Signed overflow (min/-1): no special case. The divider yields quotient=min and remainder=0; the word form sign-extends 0x8000_0000.
- Flush:
  - In any state, flush=1 returns to IDLE next edge and drops div_valid/mul_valid. Dropping valid aborts the unit.
  - out_valid is cleared and a captured result is discarded.
  - An in_valid in the same cycle as flush is not accepted.
- ok arriving in a state other than the matching WAIT_x is ignored (assertion in bench).
- Reset mid-operation: all outputs return to reset values immediately; the unit aborts via valid=0.

Decomposition:
- Shared package:
  - muldiv_op_t enum (3 bits).
  - is_div(op), res_hi(op) helper functions.
  - mul sign-mode constants.
- Sub-module muldiv_result_sel (combinational): op, w, c[127:0] -> out 64. Kept separate so writeback forwarding and the bench can reuse it.
- FSM, latches and the handshake live in muldiv_issue.

Test Plan:
- DIV a=-7 (0xFFFF_FFFF_FFFF_FFF9), b=2 -> out_data=0xFFFF_FFFF_FFFF_FFFD; REM same operands -> 0xFFFF_FFFF_FFFF_FFFF; div_valid high for exactly the divider cycles, then low.
- DIVUW a=0x1_0000_0010, b=0 -> out_data=0xFFFF_FFFF_FFFF_FFFF; REMUW same -> 0x0000_0000_0000_0010; out_valid 2 cycles after accept+1.
- DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; REMW a=0x8000_0000, b=-1 -> 0.
- MULH a=-1, b=-1 -> 0; MULHU a=-1, b=-1 -> 0xFFFF_FFFF_FFFF_FFFE; mul_valid drops cycle after mul_ok.
- Backpressure: out_ready=0 for 10 cycles after result -> out_data stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE, next op accepted following cycle.
- flush at cycle 20 of a DIV -> div_valid=0 next cycle, no out_valid; new DIVU 100/7 issued afterward -> 14.

Source files
------------

// File: rtl/muldiv_issue_pkg.sv
// Shared types and op-decode helpers for the M-extension issue/collect stage.
package muldiv_issue_pkg;

  localparam int MD_XLEN = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DIV,
    ST_WAIT_MUL,
    ST_DONE
  } md_state_t;

  // mul_signs = {a_signed, b_signed}
  localparam logic [1:0] MUL_SIGNS_SS = 2'b11;
  localparam logic [1:0] MUL_SIGNS_SU = 2'b10;
  localparam logic [1:0] MUL_SIGNS_UU = 2'b00;

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic res_hi(input muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
  endfunction

  function automatic logic div_signed(input muldiv_op_t op);
    return op inside {OP_DIV, OP_REM};
  endfunction

  function automatic logic [1:0] mul_sign_mode(input muldiv_op_t op);
    case (op)
      OP_MULH:   return MUL_SIGNS_SS;
      OP_MULHSU: return MUL_SIGNS_SU;
      default:   return MUL_SIGNS_UU;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_issue_if.sv
// Execute/writeback handshake plus the divider and multiplier request/response buses.
interface muldiv_issue_if;
  import muldiv_issue_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  muldiv_op_t             in_op;
  logic                   in_w;
  logic [MD_XLEN-1:0]     in_a;
  logic [MD_XLEN-1:0]     in_b;
  logic                   flush;

  logic                   out_valid;
  logic                   out_ready;
  logic [MD_XLEN-1:0]     out_data;

  logic                   div_valid;
  logic [MD_XLEN-1:0]     div_a;
  logic [MD_XLEN-1:0]     div_b;
  logic                   div_uors;
  logic                   div_w;
  logic                   div_ok;
  logic [2*MD_XLEN-1:0]   div_c;

  logic                   mul_valid;
  logic [MD_XLEN-1:0]     mul_a;
  logic [MD_XLEN-1:0]     mul_b;
  logic [1:0]             mul_signs;
  logic                   mul_w;
  logic                   mul_ok;
  logic [2*MD_XLEN-1:0]   mul_c;

  modport slave (
    input  in_valid, in_op, in_w, in_a, in_b, flush, out_ready,
           div_ok, div_c, mul_ok, mul_c,
    output in_ready, out_valid, out_data,
           div_valid, div_a, div_b, div_uors, div_w,
           mul_valid, mul_a, mul_b, mul_signs, mul_w
  );

  modport master (
    output in_valid, in_op, in_w, in_a, in_b, flush, out_ready,
           div_ok, div_c, mul_ok, mul_c,
    input  in_ready, out_valid, out_data,
           div_valid, div_a, div_b, div_uors, div_w,
           mul_valid, mul_a, mul_b, mul_signs, mul_w
  );

endinterface

// File: rtl/muldiv_issue_result_sel.sv
// Picks the architectural 64-bit result out of a unit's 128-bit {hi,lo} output.
module muldiv_result_sel
  import muldiv_issue_pkg::*;
(
  input  muldiv_op_t    i_op,
  input  logic          i_w,
  input  logic [127:0]  i_c,
  output logic [63:0]   o_data
);

  logic [63:0] w_sel;

  // Word forms always sign-extend bit 31, unsigned ones included.
  always_comb begin
    w_sel  = res_hi(i_op) ? i_c[127:64] : i_c[63:0];
    o_data = i_w ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
  end

endmodule

// File: rtl/muldiv_issue.sv
// Issue/collect stage in front of the iterative divider and multiplier:
// holds one op stable for the unit, captures its result, holds it for writeback.
//
// state       | meaning
// ST_IDLE     | in_ready=1, waiting for an op from execute
// ST_WAIT_DIV | div_valid=1, waiting for div_ok
// ST_WAIT_MUL | mul_valid=1, waiting for mul_ok
// ST_DONE     | out_valid=1, result held until out_ready
module muldiv_issue
  import muldiv_issue_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  muldiv_issue_if.slave   if_bus
);

  md_state_t          r_state;
  md_state_t          w_next;
  muldiv_op_t         r_op;
  logic               r_w;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  logic [XLEN-1:0]    r_res;

  logic               w_accept;
  logic               w_capture;
  logic [2*XLEN-1:0]  w_c;
  logic [XLEN-1:0]    w_sel;

  assign w_accept  = if_bus.in_valid & (r_state == ST_IDLE) & ~if_bus.flush;
  assign w_capture = ~if_bus.flush &
                     (((r_state == ST_WAIT_DIV) & if_bus.div_ok) |
                      ((r_state == ST_WAIT_MUL) & if_bus.mul_ok));
  assign w_c       = (r_state == ST_WAIT_DIV) ? if_bus.div_c : if_bus.mul_c;

  muldiv_result_sel u_sel (
    .i_op   (r_op),
    .i_w    (r_w),
    .i_c    (w_c),
    .o_data (w_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (if_bus.flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (if_bus.in_valid) w_next = is_div(if_bus.in_op) ? ST_WAIT_DIV : ST_WAIT_MUL;
        ST_WAIT_DIV: if (if_bus.div_ok)   w_next = ST_DONE;
        ST_WAIT_MUL: if (if_bus.mul_ok)   w_next = ST_DONE;
        ST_DONE:     if (if_bus.out_ready) w_next = ST_IDLE;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  // Valids decode the registered state, so they fall the cycle after ok.
  always_comb begin
    if_bus.in_ready  = (r_state == ST_IDLE);
    if_bus.out_valid = (r_state == ST_DONE);
    if_bus.div_valid = (r_state == ST_WAIT_DIV);
    if_bus.mul_valid = (r_state == ST_WAIT_MUL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= OP_MUL;
      r_w   <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else begin
      if (w_accept) begin
        r_op <= if_bus.in_op;
        r_w  <= if_bus.in_w;
        r_a  <= if_bus.in_a;
        r_b  <= if_bus.in_b;
      end
      if (if_bus.flush)   r_res <= '0;
      else if (w_capture) r_res <= w_sel;
    end
  end

  assign if_bus.out_data  = r_res;
  assign if_bus.div_a     = r_a;
  assign if_bus.div_b     = r_b;
  assign if_bus.div_uors  = div_signed(r_op);
  assign if_bus.div_w     = r_w;
  assign if_bus.mul_a     = r_a;
  assign if_bus.mul_b     = r_b;
  assign if_bus.mul_signs = mul_sign_mode(r_op);
  assign if_bus.mul_w     = r_w;

endmodule

// File: tb/tb_muldiv_issue.sv
// Self-checking bench: behavioural divider/multiplier units plus an ISA-level result model.
module tb_muldiv_issue;
  import muldiv_issue_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int TMO     = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic         tb_div_ok = 1'b0, tb_mul_ok = 1'b0;
  logic         tb_stray_div = 1'b0, tb_stray_mul = 1'b0;
  logic [127:0] tb_div_c = '0, tb_mul_c = '0, tb_stray_c = '0;
  int           div_cnt = 0, mul_cnt = 0;

  typedef struct {
    muldiv_op_t  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  muldiv_issue_if bus();

  always #5 clk = ~clk;

  assign bus.div_ok = tb_div_ok | tb_stray_div;
  assign bus.mul_ok = tb_mul_ok | tb_stray_mul;
  assign bus.div_c  = tb_stray_div ? tb_stray_c : tb_div_c;
  assign bus.mul_c  = tb_stray_mul ? tb_stray_c : tb_mul_c;

  muldiv_issue #(.XLEN(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_bus (bus)
  );

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic int div_unit_lat(input logic [63:0] b, input logic w);
    return (w ? (b[31:0] == 32'd0) : (b == 64'd0)) ? 2 : 65;
  endfunction

  function automatic int exp_unit_lat(input muldiv_op_t op, input logic w, input logic [63:0] b);
    return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) ? div_unit_lat(b, w) : MUL_LAT;
  endfunction

  // Divider unit: word ops work on 32-bit operands extended per signedness.
  function automatic logic [127:0] div_unit(input logic [63:0] a, input logic [63:0] b,
                                            input logic sgn, input logic w);
    logic [63:0] ea, eb, q, r;
    longint sa, sb;
    ea = w ? (sgn ? sx32(a[31:0]) : {32'd0, a[31:0]}) : a;
    eb = w ? (sgn ? sx32(b[31:0]) : {32'd0, b[31:0]}) : b;
    if (eb == 64'd0) begin
      q = '1; r = ea;
    end else if (sgn) begin
      if (ea == 64'h8000_0000_0000_0000 && eb == '1) begin
        q = ea; r = '0;
      end else begin
        sa = $signed(ea); sb = $signed(eb);
        q = 64'(sa / sb); r = 64'(sa % sb);
      end
    end else begin
      q = ea / eb; r = ea % eb;
    end
    return {r, q};
  endfunction

  function automatic logic [127:0] mul_unit(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] s);
    logic [127:0] ea, eb;
    ea = s[1] ? {{64{a[63]}}, a} : {64'd0, a};
    eb = s[0] ? {{64{b[63]}}, b} : {64'd0, b};
    return ea * eb;
  endfunction

  // ISA-level architectural result.
  function automatic logic [63:0] ref_result(input muldiv_op_t op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  r;
    logic [31:0]  r32;
    int           sa32, sb32;
    longint       sa, sb;
    bit           ovf32, ovf64;
    sa32  = $signed(a[31:0]);
    sb32  = $signed(b[31:0]);
    sa    = $signed(a);
    sb    = $signed(b);
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    r = '0; r32 = '0; p = '0;
    case (op)
      OP_MUL:    begin r = a * b; r32 = a[31:0] * b[31:0]; end
      OP_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      OP_MULHSU: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      OP_MULHU:  begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      OP_DIV: begin
        if (b == 0) r = '1; else if (ovf64) r = a; else r = 64'(sa / sb);
        if (b[31:0] == 0) r32 = '1; else if (ovf32) r32 = a[31:0]; else r32 = 32'(sa32 / sb32);
      end
      OP_DIVU: begin
        if (b == 0) r = '1; else r = a / b;
        if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
      end
      OP_REM: begin
        if (b == 0) r = a; else if (ovf64) r = '0; else r = 64'(sa % sb);
        if (b[31:0] == 0) r32 = a[31:0]; else if (ovf32) r32 = '0; else r32 = 32'(sa32 % sb32);
      end
      default: begin
        if (b == 0) r = a; else r = a % b;
        if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
      end
    endcase
    return w ? sx32(r32) : r;
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(1, 20));
      4:       return {32'd0, 32'($urandom)};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  // Behavioural units, driven on the falling edge.
  always @(negedge clk) begin
    if (!bus.div_valid) begin
      div_cnt   = 0;
      tb_div_ok = 1'b0;
    end else begin
      div_cnt++;
      tb_div_ok = (div_cnt == div_unit_lat(bus.div_b, bus.div_w));
      if (tb_div_ok) tb_div_c = div_unit(bus.div_a, bus.div_b, bus.div_uors, bus.div_w);
    end
    if (!bus.mul_valid) begin
      mul_cnt   = 0;
      tb_mul_ok = 1'b0;
    end else begin
      mul_cnt++;
      tb_mul_ok = (mul_cnt == MUL_LAT);
      if (tb_mul_ok) tb_mul_c = mul_unit(bus.mul_a, bus.mul_b, bus.mul_signs);
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(tb_div_ok && !bus.div_valid));
      assert (!(tb_mul_ok && !bus.mul_valid));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_out_valid(output bit to);
    int n;
    n = 0;
    while (!bus.out_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    to = !bus.out_valid;
  endtask

  // Issues one op from IDLE, scrambles the input bus after accept, collects the result.
  task automatic do_op(input muldiv_op_t op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] data,
                       output int lat, output int vcyc, output bit to);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_w = w; bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op    = muldiv_op_t'($urandom_range(0, 7));
    bus.in_w     = 1'($urandom);
    bus.in_a     = {32'($urandom), 32'($urandom)};
    bus.in_b     = {32'($urandom), 32'($urandom)};
    lat  = 1;
    vcyc = (bus.div_valid | bus.mul_valid) ? 1 : 0;
    while (!bus.out_valid && lat < TMO) begin
      @(negedge clk);
      lat++;
      if (bus.div_valid | bus.mul_valid) vcyc++;
    end
    to   = !bus.out_valid;
    data = bus.out_data;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.div_valid !== 1'b0 ||
        bus.mul_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy=%b ov=%b dv=%b mv=%b expected 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.div_valid, bus.mul_valid);
    end
    n_tests++;
    if (bus.out_data !== 64'd0 || bus.div_a !== 64'd0 || bus.div_b !== 64'd0 ||
        bus.mul_a !== 64'd0 || bus.mul_b !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data got out=%h a=%h b=%h expected all zero",
               bus.out_data, bus.div_a, bus.div_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release in_ready got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t        v[$];
    logic [63:0] d;
    int          lat, vc, ul;
    bit          to;
    v.push_back('{OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD});
    v.push_back('{OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{OP_DIVU, 1'b1, 64'h1_0000_0010, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{OP_REMU, 1'b1, 64'h1_0000_0010, 64'd0, 64'h0000_0000_0000_0010});
    v.push_back('{OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000});
    v.push_back('{OP_REM,  1'b1, 64'h8000_0000, '1, 64'd0});
    v.push_back('{OP_DIV,  1'b1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000});
    v.push_back('{OP_DIV,  1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{OP_MULH, 1'b0, '1, '1, 64'd0});
    v.push_back('{OP_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE});
    v.push_back('{OP_MULHSU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{OP_MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE});
    v.push_back('{OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14});
    foreach (v[i]) begin
      do_op(v[i].op, v[i].w, v[i].a, v[i].b, d, lat, vc, to);
      ul = exp_unit_lat(v[i].op, v[i].w, v[i].b);
      n_tests++;
      if (to || d !== v[i].exp) begin
        n_fail++;
        $display("FAIL directed[%0d] out_data got %h expected %h (timeout=%0d)", i, d, v[i].exp, to);
      end
      n_tests++;
      if (lat !== ul + 1) begin
        n_fail++;
        $display("FAIL directed[%0d] latency got %0d expected %0d", i, lat, ul + 1);
      end
      n_tests++;
      if (vc !== ul) begin
        n_fail++;
        $display("FAIL directed[%0d] unit valid cycles got %0d expected %0d", i, vc, ul);
      end
    end
  endtask

  task automatic test_random();
    muldiv_op_t  op;
    logic        w;
    logic [63:0] a, b, d, e;
    int          lat, vc;
    bit          to;
    for (int i = 0; i < 40; i++) begin
      op = muldiv_op_t'($urandom_range(0, 7));
      w  = (op inside {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU}) ? 1'($urandom) : 1'b0;
      a  = rnd_operand();
      b  = rnd_operand();
      e  = ref_result(op, w, a, b);
      do_op(op, w, a, b, d, lat, vc, to);
      n_tests++;
      if (to || d !== e || lat !== exp_unit_lat(op, w, b) + 1) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d w=%b a=%h b=%h got %h lat %0d expected %h lat %0d",
                 i, op, w, a, b, d, lat, e, exp_unit_lat(op, w, b) + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    bit bad;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_w = 1'b0; bus.in_a = 64'd6; bus.in_b = 64'd7;
    @(negedge clk);
    bus.in_op = OP_DIV; bus.in_a = 64'd9; bus.in_b = 64'd3;
    wait_out_valid(to);
    bad = to;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_data !== 64'd42 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL backpressure hold got out=%h rdy=%b ov=%b expected 42 0 1",
               bus.out_data, bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.div_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure drain got rdy=%b dv=%b expected 1 0", bus.in_ready, bus.div_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.div_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure next_accept div_valid got %b expected 1", bus.div_valid);
    end
    wait_out_valid(to);
    n_tests++;
    if (to || bus.out_data !== 64'd3) begin
      n_fail++;
      $display("FAIL backpressure second_op got %h expected 3 (timeout=%0d)", bus.out_data, to);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [63:0] d;
    int          lat, vc;
    bit          to, bad;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = OP_DIV; bus.in_w = 1'b0; bus.in_a = 64'd1000; bus.in_b = 64'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (19) @(negedge clk);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_a = 64'd5; bus.in_b = 64'd5;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    n_tests++;
    if (bus.div_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_div got dv=%b ov=%b rdy=%b expected 0 0 1",
               bus.div_valid, bus.out_valid, bus.in_ready);
    end
    bad = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (bus.out_valid | bus.div_valid | bus.mul_valid) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL flush_quiet got activity=%b expected 0", bad);
    end
    do_op(OP_DIVU, 1'b0, 64'd100, 64'd7, d, lat, vc, to);
    n_tests++;
    if (to || d !== 64'd14 || lat !== 66) begin
      n_fail++;
      $display("FAIL flush_reissue got %h lat %0d expected 14 lat 66", d, lat);
    end
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_a = 64'd3; bus.in_b = 64'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out_valid(to);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_tests++;
    if (to || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done got ov=%b rdy=%b expected 0 1 (timeout=%0d)",
               bus.out_valid, bus.in_ready, to);
    end
  endtask

  task automatic test_stray_ok();
    bit to;
    @(negedge clk);
    tb_stray_c   = {2{32'($urandom), 32'($urandom)}};
    tb_stray_div = 1'b1; tb_stray_mul = 1'b1;
    @(negedge clk);
    tb_stray_div = 1'b0; tb_stray_mul = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_idle got ov=%b rdy=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_w = 1'b0;
    bus.in_a = 64'h1234_5678; bus.in_b = 64'h10;
    @(negedge clk);
    bus.in_valid = 1'b0;
    tb_stray_div = 1'b1;
    @(negedge clk);
    tb_stray_div = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.mul_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_wait_mul got ov=%b mv=%b expected 0 1", bus.out_valid, bus.mul_valid);
    end
    wait_out_valid(to);
    n_tests++;
    if (to || bus.out_data !== 64'h1_2345_6780) begin
      n_fail++;
      $display("FAIL stray_result got %h expected 0000000123456780", bus.out_data);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = OP_REMU; bus.in_w = 1'b0; bus.in_a = 64'd77; bus.in_b = 64'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.div_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 64'd0 ||
        bus.div_a !== 64'd0 || bus.div_b !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op got dv=%b rdy=%b out=%h a=%h expected 0 1 0 0",
               bus.div_valid, bus.in_ready, bus.out_data, bus.div_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_MUL;
    bus.in_w      = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_stray_ok();
    test_reset_mid_op();
    test_directed();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
